// File: rtl/dsp_mac_sequencer.sv
// +--------------------------------------------------------------------------+
// | dsp_mac_sequencer                                                         |
// | Sequences one DSP48A1 slice as a multiply-accumulate: P = bias + sum a*b. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module dsp_mac_sequencer #(
   parameter int MULT_LAT = 3,
   parameter int LEN_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [LEN_W-1:0]  cfg_len_i,
   input  logic              cfg_use_bias_i,
   input  logic [47:0]       cfg_bias_i,
   output logic              busy_o,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [17:0]       s_a_i,
   input  logic [17:0]       s_b_i,
   output logic              result_valid_o,
   input  logic              result_ready_i,
   output logic [47:0]       result_o,
   output logic              result_carry_o,
   output logic [7:0]        dsp_opmode_o,
   output logic [17:0]       dsp_a_o,
   output logic [17:0]       dsp_b_o,
   output logic [17:0]       dsp_d_o,
   output logic [47:0]       dsp_c_o,
   output logic              dsp_cep_o,
   output logic              dsp_rst_o,
   input  logic [47:0]       dsp_p_i,
   input  logic              dsp_carryout_i
);

   localparam int          c_DLY           = MULT_LAT - 1;
   localparam int          c_DW            = $clog2(MULT_LAT + 1) + 1;
   localparam logic [7:0]  c_OP_FIRST_BIAS = 8'b0000_1101;
   localparam logic [7:0]  c_OP_FIRST_ZERO = 8'b0000_0001;
   localparam logic [7:0]  c_OP_ACCUM      = 8'b0000_1001;
   localparam logic [7:0]  c_OP_IDLE       = 8'b0000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              zero_len_q, zero_len_d;
   logic              use_bias_q, use_bias_d;
   logic [47:0]       bias_q, bias_d;
   logic              first_q, first_d;
   logic [c_DW-1:0]   drain_q, drain_d;
   logic [47:0]       result_q, result_d;
   logic              carry_q, carry_d;
   logic [c_DLY-1:0]  dly_v_q;
   logic [c_DLY-1:0]  dly_f_q;
   logic              cep_q;

   logic              term;
   logic              xfer;
   logic              s_ready;
   logic              tok_valid;
   logic              tok_first;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      zero_len_d = zero_len_q;
      use_bias_d = use_bias_q;
      bias_d     = bias_q;
      first_d    = first_q;
      drain_d    = drain_q;
      result_d   = result_q;
      carry_d    = carry_q;
      term       = 1'b0;
      xfer       = 1'b0;
      s_ready    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               cnt_d      = cfg_len_i;
               zero_len_d = (cfg_len_i == '0);
               use_bias_d = cfg_use_bias_i;
               bias_d     = cfg_bias_i;
               first_d    = 1'b1;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            // A zero-length command still pushes one a=b=0 term so the
            // accumulator is initialised to bias (or zero).
            if (zero_len_q) begin
               term    = 1'b1;
               state_d = S_DRAIN;
               drain_d = c_DW'(MULT_LAT);
            end else begin
               s_ready = 1'b1;
               if (s_valid_i) begin
                  xfer  = 1'b1;
                  term  = 1'b1;
                  cnt_d = cnt_q - LEN_W'(1);
                  if (cnt_q == LEN_W'(1)) begin
                     state_d = S_DRAIN;
                     drain_d = c_DW'(MULT_LAT);
                  end
               end
            end
            if (term) begin
               first_d = 1'b0;
            end
         end
         S_DRAIN: begin
            if (drain_q == '0) begin
               result_d = dsp_p_i;
               carry_d  = dsp_carryout_i;
               state_d  = S_HOLD;
            end else begin
               drain_d = drain_q - c_DW'(1);
            end
         end
         S_HOLD: begin
            if (result_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         zero_len_q <= 1'b0;
         use_bias_q <= 1'b0;
         bias_q     <= '0;
         first_q    <= 1'b0;
         drain_q    <= '0;
         result_q   <= '0;
         carry_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         zero_len_q <= zero_len_d;
         use_bias_q <= use_bias_d;
         bias_q     <= bias_d;
         first_q    <= first_d;
         drain_q    <= drain_d;
         result_q   <= result_d;
         carry_q    <= carry_d;
      end
   end

   // Term tokens track the operands through A0/A1 so opmode reaches the
   // OPMODE register one cycle before the product lands in M.
   always_ff @(posedge clk) begin
      if (rst) begin
         dly_v_q <= '0;
         dly_f_q <= '0;
         cep_q   <= 1'b0;
      end else begin
         dly_v_q[0] <= term;
         dly_f_q[0] <= term & first_q;
         for (int i = 1; i < c_DLY; i++) begin
            dly_v_q[i] <= dly_v_q[i-1];
            dly_f_q[i] <= dly_f_q[i-1];
         end
         cep_q <= dly_v_q[c_DLY-1];
      end
   end

   assign tok_valid = dly_v_q[c_DLY-1];
   assign tok_first = dly_f_q[c_DLY-1];

   always_comb begin
      dsp_opmode_o = c_OP_IDLE;
      if (tok_valid) begin
         if (!tok_first) begin
            dsp_opmode_o = c_OP_ACCUM;
         end else if (use_bias_q) begin
            dsp_opmode_o = c_OP_FIRST_BIAS;
         end else begin
            dsp_opmode_o = c_OP_FIRST_ZERO;
         end
      end
   end

   assign busy_o         = (state_q != S_IDLE);
   assign s_ready_o      = s_ready;
   assign result_valid_o = (state_q == S_HOLD);
   assign result_o       = result_q;
   assign result_carry_o = carry_q;
   assign dsp_a_o        = xfer ? s_a_i : 18'd0;
   assign dsp_b_o        = xfer ? s_b_i : 18'd0;
   assign dsp_d_o        = 18'd0;
   assign dsp_c_o        = bias_q;
   assign dsp_cep_o      = cep_q;
   assign dsp_rst_o      = rst;

endmodule

`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a cycle model of the DSP48A1 slice
// (A0/A1/M, C, OPMODE and P registers enabled; only P gated by cep).
`default_nettype none

module tb_dsp_mac_sequencer;

   localparam int MULT_LAT = 3;
   localparam int LEN_W    = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  cfg_len;
   logic        cfg_use_bias;
   logic [47:0] cfg_bias;
   logic        busy;
   logic        s_valid;
   logic        s_ready;
   logic [17:0] s_a, s_b;
   logic        result_valid;
   logic        result_ready;
   logic [47:0] result;
   logic        result_carry;
   logic [7:0]  dsp_opmode;
   logic [17:0] dsp_a, dsp_b, dsp_d;
   logic [47:0] dsp_c;
   logic        dsp_cep;
   logic        dsp_rst;
   logic [47:0] dsp_p;
   logic        dsp_carryout;

   always #5 clk = ~clk;

   dsp_mac_sequencer #(.MULT_LAT(MULT_LAT), .LEN_W(LEN_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start),
      .cfg_len_i      (cfg_len),
      .cfg_use_bias_i (cfg_use_bias),
      .cfg_bias_i     (cfg_bias),
      .busy_o         (busy),
      .s_valid_i      (s_valid),
      .s_ready_o      (s_ready),
      .s_a_i          (s_a),
      .s_b_i          (s_b),
      .result_valid_o (result_valid),
      .result_ready_i (result_ready),
      .result_o       (result),
      .result_carry_o (result_carry),
      .dsp_opmode_o   (dsp_opmode),
      .dsp_a_o        (dsp_a),
      .dsp_b_o        (dsp_b),
      .dsp_d_o        (dsp_d),
      .dsp_c_o        (dsp_c),
      .dsp_cep_o      (dsp_cep),
      .dsp_rst_o      (dsp_rst),
      .dsp_p_i        (dsp_p),
      .dsp_carryout_i (dsp_carryout)
   );

   // ---------------- DSP48A1 slice model ----------------
   logic signed [17:0] m_a0, m_b0, m_a1, m_b1;
   logic signed [35:0] m_m;
   logic [47:0]        m_c, m_p;
   logic [7:0]         m_op;
   logic               m_co;
   logic [47:0]        xmux, zmux;

   always_comb begin
      xmux = 48'd0;
      if (m_op[1:0] == 2'b01 && m_op[7:4] == 4'd0) xmux = {{12{m_m[35]}}, m_m};
      case (m_op[3:2])
         2'b10:   zmux = m_p;
         2'b11:   zmux = m_c;
         default: zmux = 48'd0;
      endcase
   end

   always @(posedge clk) begin
      if (dsp_rst) begin
         m_a0 <= '0; m_b0 <= '0; m_a1 <= '0; m_b1 <= '0; m_m <= '0;
         m_c <= '0; m_p <= '0; m_op <= '0; m_co <= 1'b0;
      end else begin
         m_a0 <= dsp_a;
         m_b0 <= dsp_b;
         m_a1 <= m_a0;
         m_b1 <= m_b0;
         m_m  <= m_a1 * m_b1;
         m_c  <= dsp_c;
         m_op <= dsp_opmode;
         if (dsp_cep) {m_co, m_p} <= {1'b0, zmux} + {1'b0, xmux} + {31'd0, dsp_d};
      end
   end

   assign dsp_p        = m_p;
   assign dsp_carryout = m_co;

   // ---------------- free-running monitors ----------------
   int cyc = 0;
   int cep_cnt = 0;
   int sready_cnt = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (dsp_cep) cep_cnt <= cep_cnt + 1;
      if (s_ready) sready_cnt <= sready_cnt + 1;
   end

   // ---------------- checking ----------------
   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic [7:0]        len;
      logic              use_bias;
      logic [47:0]       bias;
      logic [3:0][17:0]  a;
      logic [3:0][17:0]  b;
      logic [3:0]        gap;
      logic [47:0]       exp_res;
      logic              exp_carry;
   } vec_t;

   typedef struct packed {
      logic [47:0] res;
      logic        carry;
   } exp_t;

   exp_t sb[$];
   vec_t tbl [8];

   function automatic vec_t mk(input logic [7:0] len, input logic ub, input logic [47:0] bias,
                               input logic [17:0] a0, b0, a1, b1, a2, b2, a3, b3,
                               input logic [3:0] gap, input logic [47:0] res, input logic cy);
      vec_t t;
      t.len = len; t.use_bias = ub; t.bias = bias; t.gap = gap;
      t.a[0] = a0; t.b[0] = b0; t.a[1] = a1; t.b[1] = b1;
      t.a[2] = a2; t.b[2] = b2; t.a[3] = a3; t.b[3] = b3;
      t.exp_res = res; t.exp_carry = cy;
      return t;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_s_ready"}, 64'(s_ready), 0);
      chk({tag, "_result_valid"}, 64'(result_valid), 0);
      chk({tag, "_result"}, 64'(result), 0);
      chk({tag, "_carry"}, 64'(result_carry), 0);
      chk({tag, "_opmode"}, 64'(dsp_opmode), 0);
      chk({tag, "_dsp_ab"}, {28'd0, dsp_a, dsp_b}, 0);
      chk({tag, "_dsp_c"}, 64'(dsp_c), 0);
      chk({tag, "_dsp_d"}, 64'(dsp_d), 0);
      chk({tag, "_cep"}, 64'(dsp_cep), 0);
      chk({tag, "_dsp_rst"}, 64'(dsp_rst), 1);
   endtask

   // Issue one command, stream its pairs, then collect the result against
   // the scoreboard. stall > 0 holds result_ready low that many cycles.
   task automatic run_vec(input vec_t t, input int stall, input logic poke_start);
      int   L, R, n, cep0, sr0, exp_ceps;
      exp_t e;
      cep0 = cep_cnt;
      sr0  = sready_cnt;
      start = 1'b1; cfg_len = t.len; cfg_use_bias = t.use_bias; cfg_bias = t.bias;
      tick();
      start = 1'b0; cfg_len = 8'd0; cfg_use_bias = 1'b0; cfg_bias = 48'd0;
      sb.push_back('{res: t.exp_res, carry: t.exp_carry});
      chk("busy_after_start", 64'(busy), 1);
      L = cyc;
      for (int k = 0; k < int'(t.len); k++) begin
         if (k > 0) repeat (int'(t.gap)) tick();
         s_valid = 1'b1; s_a = t.a[k]; s_b = t.b[k];
         n = 0;
         while (!s_ready && n < 20) begin tick(); n++; end
         if (!s_ready) chk("s_ready_timeout", 64'(s_ready), 1);
         L = cyc;
         tick();
         s_valid = 1'b0; s_a = 18'd0; s_b = 18'd0;
      end
      n = 0;
      while (!result_valid && n < 50) begin tick(); n++; end
      R = cyc;
      e = sb.pop_front();
      if (!result_valid) begin
         chk("result_timeout", 64'(result_valid), 1);
      end else begin
         chk("latency", 64'(R - L), 64'(MULT_LAT + 2));
         for (int i = 0; i < stall; i++) begin
            if (poke_start && i == 4) begin
               start = 1'b1; cfg_len = 8'd5; cfg_use_bias = 1'b1; cfg_bias = 48'd7;
            end
            tick();
            start = 1'b0; cfg_len = 8'd0; cfg_use_bias = 1'b0; cfg_bias = 48'd0;
            chk("hold_valid", 64'(result_valid), 1);
            chk("hold_result", 64'(result), 64'(e.res));
            chk("hold_busy", 64'(busy), 1);
         end
         chk("result", 64'(result), 64'(e.res));
         chk("carry", 64'(result_carry), 64'(e.carry));
         result_ready = 1'b1;
         tick();
         result_ready = 1'b0;
         chk("busy_after_handshake", 64'(busy), 0);
         chk("valid_after_handshake", 64'(result_valid), 0);
      end
      exp_ceps = (t.len == 8'd0) ? 1 : int'(t.len);
      chk("cep_pulses", 64'(cep_cnt - cep0), 64'(exp_ceps));
      if (t.len == 8'd0) chk("s_ready_never_high", 64'(sready_cnt - sr0), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; cfg_len = 8'd0; cfg_use_bias = 1'b0; cfg_bias = 48'd0;
      s_valid = 1'b0; s_a = 18'd0; s_b = 18'd0; result_ready = 1'b0;

      tbl[0] = mk(8'd3, 1'b0, 48'd0, 18'd10, 18'd20, 18'd2, 18'd5, 18'd3, 18'd4, 18'd0, 18'd0,
                  4'd0, 48'd222, 1'b0);
      tbl[1] = mk(8'd3, 1'b1, 48'd40, 18'd10, 18'd20, 18'd2, 18'd5, 18'd3, 18'd4, 18'd0, 18'd0,
                  4'd2, 48'd262, 1'b0);
      tbl[2] = mk(8'd0, 1'b1, 48'd40, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0,
                  4'd0, 48'd40, 1'b0);
      tbl[3] = mk(8'd0, 1'b0, 48'd40, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0,
                  4'd0, 48'd0, 1'b0);
      tbl[4] = mk(8'd2, 1'b1, 48'hFFFF_FFFF_FFFF, 18'd1, 18'd1, 18'd0, 18'd0, 18'd0, 18'd0,
                  18'd0, 18'd0, 4'd0, 48'd0, 1'b0);
      tbl[5] = mk(8'd1, 1'b1, 48'hFFFF_FFFF_FFFF, 18'd1, 18'd1, 18'd0, 18'd0, 18'd0, 18'd0,
                  18'd0, 18'd0, 4'd0, 48'd0, 1'b1);
      tbl[6] = mk(8'd2, 1'b0, 48'd0, -18'sd3, 18'd7, 18'd100, -18'sd2, 18'd0, 18'd0, 18'd0, 18'd0,
                  4'd0, 48'hFFFF_FFFF_FF23, 1'b1);
      tbl[7] = mk(8'd4, 1'b1, 48'd1000, 18'd1000, 18'd1000, -18'sd1, 18'd5, 18'd7, 18'd7,
                  18'd0, 18'd9, 4'd1, 48'hF_4654, 1'b0);

      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      for (int v = 0; v < 8; v++) run_vec(tbl[v], 0, 1'b0);

      // Result held 10 cycles with a start pulse during HOLD, then normal reuse.
      run_vec(tbl[1], 10, 1'b1);
      run_vec(tbl[0], 0, 1'b0);

      // Reset the cycle after the second of three transfers.
      start = 1'b1; cfg_len = 8'd3; cfg_use_bias = 1'b1; cfg_bias = 48'd99;
      tick();
      start = 1'b0; cfg_len = 8'd0; cfg_use_bias = 1'b0; cfg_bias = 48'd0;
      s_valid = 1'b1; s_a = 18'd10; s_b = 18'd20;
      tick();
      s_a = 18'd2; s_b = 18'd5;
      tick();
      s_valid = 1'b0; s_a = 18'd0; s_b = 18'd0;
      rst = 1'b1;
      tick();
      check_reset_outputs("midrst");
      rst = 1'b0;
      tick();
      run_vec(mk(8'd1, 1'b0, 48'd0, 18'd10, 18'd20, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0,
                 4'd0, 48'd200, 1'b0), 0, 1'b0);

      chk("scoreboard_empty", 64'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

- Drives one DSP48A1 slice (`DSP` module, all pipeline registers enabled) as a multiply-accumulate engine.
- Accepts a command: term count, optional 48-bit bias. Then accepts `cfg_len` operand pairs over a valid/ready stream and drives `opmode`, operands and `cep` so that P = bias + Σ a·b.
- Waits out the slice pipeline, captures P, and presents the result on a valid/ready output.
- Sits between the control/stream logic and the DSP instance; it is the only driver of the slice's control inputs.

## Interface

Parameters:
- MULT_LAT, 3: cycles from operand at DSP `a`/`b` ports to product in M register (A0REG+A1REG+MREG).
- LEN_W, 8: width of term count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command pulse; sampled only in IDLE.
- cfg_len  in  LEN_W  number of terms; sampled with start.
- cfg_use_bias  in  1  1 = initialise accumulator with cfg_bias, 0 = with zero.
- cfg_bias  in  48  bias value; latched at start.
- busy  out  1  high in any state other than IDLE.
- s_valid  in  1  operand pair valid.
- s_ready  out  1  sequencer accepts operand pair.
- s_a, s_b  in  18 each  operand pair.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- result  out  48  captured P.
- result_carry  out  1  captured DSP carryout.
- dsp_opmode  out  8  to DSP `opmode`.
- dsp_a, dsp_b  out  18 each  to DSP `a`, `b`.
- dsp_d  out  18  tied to 0.
- dsp_c  out  48  latched bias.
- dsp_cep  out  1  to DSP `cep`.
- dsp_rst  out  1  to every DSP `rst*` input; equals rst.
- dsp_p  in  48  from DSP `p`.
- dsp_carryout  in  1  from DSP `carryout`.

Fixed DSP enables: cea/ceb/cem/cec/ced/cecarryin/ceopmode tied to 1 at integration. Only cep is gated.

## Operation

States: IDLE, LOAD, DRAIN, HOLD.
- IDLE: on start, latch cfg_len into term counter, latch cfg_use_bias and cfg_bias, go to LOAD.
- LOAD: s_ready = 1. A transfer is a cycle with s_valid & s_ready.
  - On a transfer, dsp_a = s_a and dsp_b = s_b (combinational). Otherwise both are 0.
  - Each transfer decrements the counter.
  - After the last transfer, go to DRAIN.
- cfg_len = 0: LOAD issues one internal term with a = b = 0 and no stream handshake (s_ready stays 0). Result = bias or 0.
- Opmode per term (pre-adder bypassed, no carryin):
  - First term, with bias: 8'b0000_1101 (X = M, Z = C).
  - First term, no bias: 8'b0000_0001 (X = M, Z = 0).
  - Later terms: 8'b0000_1001 (X = M, Z = P).
  - Non-term cycles: 8'b0000_0000.
- Alignment: a per-term {valid, first} token goes through a delay line of MULT_LAT−1 stages.
  - dsp_opmode is driven from the delay-line output.
  - dsp_cep = 1 one cycle after the delay-line output valid, i.e. in the cycle the product is in M, so P updates exactly once per term.
- Stream bubbles (s_valid low) inject no term. The delay line carries invalid tokens; cep stays 0 and P holds.
- DRAIN: counter runs MULT_LAT+1 cycles after the last transfer. Then capture dsp_p → result and dsp_carryout → result_carry, and go to HOLD.
- HOLD: result_valid = 1. Result is stable until result_ready. On result_valid & result_ready, go to IDLE.
- start while busy is ignored.
- Arithmetic is the slice's 48-bit two's complement. Overflow wraps; carry is reported, not saturated.
- rst in any state:
  - next state IDLE, delay line cleared, latched bias cleared;
  - all outputs return to reset values; any in-flight accumulation is discarded.

## Timing

- Reset values: busy 0, s_ready 0, result_valid 0, result 0, result_carry 0, dsp_opmode 0, dsp_a/b/c/d 0, dsp_cep 0. dsp_rst follows rst.
- start sampled at cycle 0 → LOAD at cycle 1; s_ready high from cycle 1.
- Last transfer at cycle L:
  - first-term opmode at DSP input at cycle (first transfer)+MULT_LAT−1;
  - P final at L+MULT_LAT+1;
  - result_valid at L+MULT_LAT+2.
- Back-to-back: a new start is accepted the cycle after the result handshake. There is no overlap between commands.
- Maximum throughput: one term per cycle.

## Test plan

- cfg_len = 3, no bias, pairs (10,20), (2,5), (3,4) on consecutive cycles → result = 222, result_valid exactly MULT_LAT+2 cycles after the third transfer, carry 0.
- Same pairs, cfg_use_bias = 1, cfg_bias = 40, s_valid low for 2 cycles between terms → result = 262; dsp_cep pulses exactly 3 times.
- cfg_len = 0, bias 40 → s_ready never high; result = 40. Repeat without bias → result = 0.
- result_ready held low 10 cycles in HOLD → result_valid and result stable. A start pulse during HOLD is ignored; busy stays 1.
- rst asserted in the cycle after the second of 3 transfers → next cycle all outputs at reset values and state IDLE. A new cfg_len = 1, (10,20) command then gives 200.
- cfg_len = 2, bias 48'hFFFF_FFFF_FFFF, pairs (1,1), (0,0) → result = 0 (wrap). result_carry equals the slice carryout.
